// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - runtime-reconfigurable raster timing generator
// New timing sets are held pending and swapped in on the last pixel of a frame.
module video_timing_gen #(
  parameter int CW       = 12,
  parameter int LATENCY  = 1,
  parameter int TRIG_DIV = 1,
  parameter int H_VIS    = 640,
  parameter int H_FP     = 16,
  parameter int H_SW     = 96,
  parameter int H_BP     = 48,
  parameter int V_VIS    = 480,
  parameter int V_FP     = 10,
  parameter int V_SW     = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cfg_load,
  input  logic [CW-1:0] cfg_h_vis,
  input  logic [CW-1:0] cfg_h_fp,
  input  logic [CW-1:0] cfg_h_sw,
  input  logic [CW-1:0] cfg_h_bp,
  input  logic [CW-1:0] cfg_v_vis,
  input  logic [CW-1:0] cfg_v_fp,
  input  logic [CW-1:0] cfg_v_sw,
  input  logic [CW-1:0] cfg_v_bp,
  input  logic          cfg_h_pol,
  input  logic          cfg_v_pol,
  input  logic          trig_enable,
  output logic          cfg_busy,
  output logic          cfg_error,
  output logic [CW-1:0] counterX,
  output logic [CW-1:0] counterY,
  output logic [CW-1:0] visible_counterX,
  output logic [CW-1:0] visible_counterY,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic          frame_start,
  output logic          starttrigger
);

  localparam int TW = CW + 2;
  localparam int W  = 4 * CW + 5;

  typedef struct packed {
    logic [CW-1:0] h_vis;
    logic [CW-1:0] h_fp;
    logic [CW-1:0] h_sw;
    logic [CW-1:0] h_bp;
    logic [CW-1:0] v_vis;
    logic [CW-1:0] v_fp;
    logic [CW-1:0] v_sw;
    logic [CW-1:0] v_bp;
    logic          h_pol;
    logic          v_pol;
  } timing_t;

  localparam timing_t RST_CFG = '{
    h_vis: CW'(H_VIS), h_fp: CW'(H_FP), h_sw: CW'(H_SW), h_bp: CW'(H_BP),
    v_vis: CW'(V_VIS), v_fp: CW'(V_FP), v_sw: CW'(V_SW), v_bp: CW'(V_BP),
    h_pol: 1'(H_POL), v_pol: 1'(V_POL)
  };

  localparam logic [W-1:0] RST_WORD = {{(4*CW){1'b0}}, 1'b0, ~1'(H_POL), ~1'(V_POL), 2'b00};

  function automatic logic [TW-1:0] sum4(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                         input logic [CW-1:0] c, input logic [CW-1:0] d);
    return {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
  endfunction

  timing_t       act;
  timing_t       pend;
  timing_t       cfg_in;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic [15:0]   fidx;
  logic          busy;

  logic [TW-1:0] h_total;
  logic [TW-1:0] v_total;
  logic [TW-1:0] in_h_total;
  logic [TW-1:0] in_v_total;
  logic          load_ok;
  logic          line_end;
  logic          last_px;

  assign cfg_in = {cfg_h_vis, cfg_h_fp, cfg_h_sw, cfg_h_bp,
                   cfg_v_vis, cfg_v_fp, cfg_v_sw, cfg_v_bp, cfg_h_pol, cfg_v_pol};

  assign h_total    = sum4(act.h_vis, act.h_fp, act.h_sw, act.h_bp);
  assign v_total    = sum4(act.v_vis, act.v_fp, act.v_sw, act.v_bp);
  assign in_h_total = sum4(cfg_h_vis, cfg_h_fp, cfg_h_sw, cfg_h_bp);
  assign in_v_total = sum4(cfg_v_vis, cfg_v_fp, cfg_v_sw, cfg_v_bp);

  // A total that does not fit in CW bits could never be reached by the counters.
  assign load_ok  = cfg_load && (cfg_h_vis != '0) && (cfg_v_vis != '0) &&
                    (in_h_total[TW-1:CW] == 2'b00) && (in_v_total[TW-1:CW] == 2'b00);
  assign line_end = ({2'b00, x} == h_total - TW'(1));
  assign last_px  = line_end && ({2'b00, y} == v_total - TW'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      act       <= RST_CFG;
      pend      <= '0;
      busy      <= 1'b0;
      cfg_error <= 1'b0;
      x         <= '0;
      y         <= '0;
      fidx      <= '0;
    end else begin
      cfg_error <= cfg_load && !load_ok;
      if (last_px) begin
        x    <= '0;
        y    <= '0;
        busy <= 1'b0;
        fidx <= (fidx == 16'(TRIG_DIV - 1)) ? 16'd0 : fidx + 16'd1;
        // A load landing on the boundary cycle takes effect immediately.
        if (load_ok) begin
          act  <= cfg_in;
          pend <= cfg_in;
        end else if (busy) begin
          act <= pend;
        end
      end else begin
        if (line_end) begin
          x <= '0;
          y <= y + CW'(1);
        end else begin
          x <= x + CW'(1);
        end
        if (load_ok) begin
          pend <= cfg_in;
          busy <= 1'b1;
        end
      end
    end
  end

  assign cfg_busy = busy;

  logic [TW-1:0] hs_start;
  logic [TW-1:0] hs_end;
  logic [TW-1:0] vs_start;
  logic [TW-1:0] vs_end;
  logic          de_c;
  logic          hs_c;
  logic          vs_c;
  logic          fs_c;
  logic          st_c;
  logic [W-1:0]  word;

  assign hs_start = {2'b00, act.h_vis} + {2'b00, act.h_fp};
  assign hs_end   = hs_start + {2'b00, act.h_sw};
  assign vs_start = {2'b00, act.v_vis} + {2'b00, act.v_fp};
  assign vs_end   = vs_start + {2'b00, act.v_sw};

  assign de_c = (x < act.h_vis) && (y < act.v_vis);
  assign hs_c = (({2'b00, x} >= hs_start) && ({2'b00, x} < hs_end)) ? act.h_pol : ~act.h_pol;
  assign vs_c = (({2'b00, y} >= vs_start) && ({2'b00, y} < vs_end)) ? act.v_pol : ~act.v_pol;
  assign fs_c = (x == '0) && (y == '0);
  assign st_c = fs_c && (fidx == 16'd0) && trig_enable;

  assign word = {de_c ? x : {CW{1'b0}}, de_c ? y : {CW{1'b0}}, x, y, de_c, hs_c, vs_c, fs_c, st_c};

  logic [W-1:0] pipe [LATENCY];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= RST_WORD;
    end else begin
      pipe[0] <= word;
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign {visible_counterX, visible_counterY, counterX, counterY,
          de, hsync, vsync, frame_start, starttrigger} = pipe[LATENCY-1];

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - directed and random checks of video_timing_gen
// Reference raster is kept as a per-cycle history; each DUT output is history delayed by its latency.
module tb_video_timing_gen;
  localparam int CW = 12;
  localparam int TD = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic cfg_load = 1'b0;
  logic [CW-1:0] c_hv = '0, c_hf = '0, c_hs = '0, c_hb = '0;
  logic [CW-1:0] c_vv = '0, c_vf = '0, c_vs = '0, c_vb = '0;
  logic c_hp = 1'b0, c_vp = 1'b0;
  logic trig_enable = 1'b1;

  logic          busy1, err1, de1, hs1, vs1, fs1, st1;
  logic [CW-1:0] x1, y1, vx1, vy1;
  logic          busy4, err4, de4, hs4, vs4, fs4, st4;
  logic [CW-1:0] x4, y4, vx4, vy4;

  video_timing_gen #(.CW(CW), .LATENCY(1), .TRIG_DIV(TD),
    .H_VIS(4), .H_FP(1), .H_SW(2), .H_BP(1), .V_VIS(3), .V_FP(1), .V_SW(1), .V_BP(1),
    .H_POL(0), .V_POL(0)) dut1 (
    .clock(clock), .reset(reset), .cfg_load(cfg_load),
    .cfg_h_vis(c_hv), .cfg_h_fp(c_hf), .cfg_h_sw(c_hs), .cfg_h_bp(c_hb),
    .cfg_v_vis(c_vv), .cfg_v_fp(c_vf), .cfg_v_sw(c_vs), .cfg_v_bp(c_vb),
    .cfg_h_pol(c_hp), .cfg_v_pol(c_vp), .trig_enable(trig_enable),
    .cfg_busy(busy1), .cfg_error(err1), .counterX(x1), .counterY(y1),
    .visible_counterX(vx1), .visible_counterY(vy1), .de(de1), .hsync(hs1), .vsync(vs1),
    .frame_start(fs1), .starttrigger(st1));

  video_timing_gen #(.CW(CW), .LATENCY(4), .TRIG_DIV(TD),
    .H_VIS(4), .H_FP(1), .H_SW(2), .H_BP(1), .V_VIS(3), .V_FP(1), .V_SW(1), .V_BP(1),
    .H_POL(0), .V_POL(0)) dut4 (
    .clock(clock), .reset(reset), .cfg_load(cfg_load),
    .cfg_h_vis(c_hv), .cfg_h_fp(c_hf), .cfg_h_sw(c_hs), .cfg_h_bp(c_hb),
    .cfg_v_vis(c_vv), .cfg_v_fp(c_vf), .cfg_v_sw(c_vs), .cfg_v_bp(c_vb),
    .cfg_h_pol(c_hp), .cfg_v_pol(c_vp), .trig_enable(trig_enable),
    .cfg_busy(busy4), .cfg_error(err4), .counterX(x4), .counterY(y4),
    .visible_counterX(vx4), .visible_counterY(vy4), .de(de4), .hsync(hs4), .vsync(vs4),
    .frame_start(fs4), .starttrigger(st4));

  always #5 clock = ~clock;

  typedef struct {
    int vx; int vy; int x; int y; int de; int hs; int vs; int fs; int st;
  } ent_t;

  ent_t hist[$];
  int   n;
  int   a[10];
  int   p[10];
  int   mx, my, fidx;
  int   busy_e, err_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0, last_fs = -1, period = 0, fs_cnt = 0, st_cnt = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic ent_t rst_ent();
    ent_t e = '{0, 0, 0, 0, 0, 1, 1, 0, 0};
    return e;
  endfunction

  // Raster rules evaluated directly from the active timing set and model position.
  function automatic ent_t model_out();
    ent_t e;
    int hs0 = a[0] + a[1];
    int vs0 = a[4] + a[5];
    e.x  = mx;
    e.y  = my;
    e.de = (mx < a[0] && my < a[4]) ? 1 : 0;
    e.vx = e.de ? mx : 0;
    e.vy = e.de ? my : 0;
    e.hs = (mx >= hs0 && mx < hs0 + a[2]) ? a[8] : 1 - a[8];
    e.vs = (my >= vs0 && my < vs0 + a[6]) ? a[9] : 1 - a[9];
    e.fs = (mx == 0 && my == 0) ? 1 : 0;
    e.st = (e.fs == 1 && fidx == 0 && trig_enable == 1'b1) ? 1 : 0;
    return e;
  endfunction

  function automatic ent_t get_obs(input int which);
    ent_t e;
    if (which == 1) e = '{int'(vx1), int'(vy1), int'(x1), int'(y1), int'(de1), int'(hs1), int'(vs1), int'(fs1), int'(st1)};
    else            e = '{int'(vx4), int'(vy4), int'(x4), int'(y4), int'(de4), int'(hs4), int'(vs4), int'(fs4), int'(st4)};
    return e;
  endfunction

  function automatic ent_t exp_at(input int lat);
    if (n < lat) return rst_ent();
    return hist[n - lat];
  endfunction

  task automatic cmp_ent(input string pfx, input ent_t o, input ent_t e);
    chk({pfx, "_vx"}, o.vx, e.vx);
    chk({pfx, "_vy"}, o.vy, e.vy);
    chk({pfx, "_x"},  o.x,  e.x);
    chk({pfx, "_y"},  o.y,  e.y);
    chk({pfx, "_de"}, o.de, e.de);
    chk({pfx, "_hs"}, o.hs, e.hs);
    chk({pfx, "_vs"}, o.vs, e.vs);
    chk({pfx, "_fs"}, o.fs, e.fs);
    chk({pfx, "_st"}, o.st, e.st);
  endtask

  task automatic model_reset();
    a = '{4, 1, 2, 1, 3, 1, 1, 1, 0, 0};
    p = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    mx = 0; my = 0; fidx = 0; busy_e = 0; err_e = 0;
    hist.delete();
    n = 0;
  endtask

  task automatic model_step();
    int in_[10];
    int ht, vt, ok, last;
    in_ = '{int'(c_hv), int'(c_hf), int'(c_hs), int'(c_hb), int'(c_vv), int'(c_vf),
            int'(c_vs), int'(c_vb), int'(c_hp), int'(c_vp)};
    ht = a[0] + a[1] + a[2] + a[3];
    vt = a[4] + a[5] + a[6] + a[7];
    ok = (cfg_load && in_[0] != 0 && in_[4] != 0 &&
          in_[0] + in_[1] + in_[2] + in_[3] < 4096 &&
          in_[4] + in_[5] + in_[6] + in_[7] < 4096) ? 1 : 0;
    err_e = (cfg_load && ok == 0) ? 1 : 0;
    last  = (mx == ht - 1 && my == vt - 1) ? 1 : 0;
    if (last) begin
      mx = 0; my = 0;
      fidx = (fidx + 1) % TD;
      if (ok) a = in_;
      else if (busy_e) a = p;
      busy_e = 0;
    end else begin
      mx++;
      if (mx == ht) begin mx = 0; my++; end
      if (ok) begin p = in_; busy_e = 1; end
    end
  endtask

  task automatic tick();
    ent_t e = model_out();
    @(posedge clock);
    hist.push_back(e);
    n++;
    model_step();
    @(negedge clock);
    cyc++;
    cmp_ent("lat1", get_obs(1), exp_at(1));
    cmp_ent("lat4", get_obs(4), exp_at(4));
    chk("busy1", int'(busy1), busy_e);
    chk("err1", int'(err1), err_e);
    chk("busy4", int'(busy4), busy_e);
    chk("err4", int'(err4), err_e);
    if (fs1) begin
      if (last_fs >= 0) period = cyc - last_fs;
      last_fs = cyc;
      fs_cnt++;
    end
    if (st1) st_cnt++;
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic set_cfg(input int hv, input int hf, input int hs, input int hb,
                         input int vv, input int vf, input int vs, input int vb,
                         input int hp, input int vp);
    c_hv = CW'(hv); c_hf = CW'(hf); c_hs = CW'(hs); c_hb = CW'(hb);
    c_vv = CW'(vv); c_vf = CW'(vf); c_vs = CW'(vs); c_vb = CW'(vb);
    c_hp = 1'(hp); c_vp = 1'(vp);
  endtask

  task automatic load_once();
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    cmp_ent({pfx, "_l1"}, get_obs(1), rst_ent());
    cmp_ent({pfx, "_l4"}, get_obs(4), rst_ent());
    chk({pfx, "_busy"}, int'(busy1), 0);
    chk({pfx, "_err"}, int'(err1), 0);
  endtask

  task automatic random_phase(input int k);
    for (int i = 0; i < k; i++) begin
      cfg_load = ($urandom_range(0, 19) == 0);
      if (cfg_load) begin
        set_cfg(($urandom_range(0, 9) == 0) ? 4090 : $urandom_range(0, 5),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1));
      end
      if ($urandom_range(0, 49) == 0) trig_enable = ~trig_enable;
      tick();
    end
    cfg_load = 1'b0;
  endtask

  initial begin
    int k;
    model_reset();
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;

    ticks(48 * 7);
    chk("param_period", period, 48);
    chk("frame_starts", fs_cnt, 7);
    chk("triggers_0_3_6", st_cnt, 3);

    // Reset while a config is pending on line 2.
    set_cfg(2, 1, 1, 1, 2, 1, 1, 1, 1, 1);
    load_once();
    k = 0;
    while (my != 2 && k < 200) begin tick(); k++; end
    chk("reach_line2", my, 2);
    chk("pending_busy", int'(busy1), 1);
    #1 reset = 1'b1;
    #1 check_reset_outputs("async_rst");
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    last_fs = -1; period = 0;
    ticks(120);
    chk("post_rst_period", period, 48);
    chk("post_rst_busy", int'(busy1), 0);

    // Mid-frame reconfiguration.
    set_cfg(2, 1, 1, 1, 2, 1, 1, 1, 1, 1);
    load_once();
    chk("busy_after_load", int'(busy1), 1);
    ticks(100);
    chk("new_period", period, 25);
    chk("busy_cleared", int'(busy1), 0);

    // Rejected loads leave timing and busy untouched.
    set_cfg(0, 1, 1, 1, 2, 1, 1, 1, 0, 0);
    load_once();
    chk("err_hvis0", int'(err1), 1);
    chk("busy_hvis0", int'(busy1), 0);
    set_cfg(4000, 32, 32, 32, 2, 1, 1, 1, 0, 0);
    load_once();
    chk("err_total4096", int'(err1), 1);
    tick();
    chk("err_one_cycle", int'(err1), 0);
    trig_enable = 1'b0;
    st_cnt = 0;
    ticks(100);
    chk("period_unchanged", period, 25);
    chk("no_trig_disabled", st_cnt, 0);
    trig_enable = 1'b1;

    random_phase(1500);

    set_cfg(4, 1, 2, 1, 3, 1, 1, 1, 0, 0);
    load_once();
    ticks(200);
    random_phase(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised, runtime-reconfigurable raster timing generator; successor to the fixed-mode timing generator in the video pipeline. Produces pixel/line counters, visible-area counters, DE, HSYNC, VSYNC and a frame-gated start trigger for the downstream text/pattern generators. Accepts a new timing set at any time and applies it glitch-free at the frame boundary. All outputs pass through a LATENCY-deep delay line to align with the pixel pipeline.

## Interface
- CW, 12, width of all timing fields and counters
- LATENCY, 1, output register stages (1..4)
- TRIG_DIV, 1, starttrigger fires every TRIG_DIV-th frame (1..65535)
- H_VIS/H_FP/H_SW/H_BP, 640/16/96/48, reset horizontal timing
- V_VIS/V_FP/V_SW/V_BP, 480/10/2/33, reset vertical timing
- H_POL/V_POL, 0/0, reset sync polarity (1 = active-high)

- clock  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- cfg_load  in  1  one-cycle strobe capturing cfg_* fields
- cfg_h_vis, cfg_h_fp, cfg_h_sw, cfg_h_bp  in  CW each  horizontal timing
- cfg_v_vis, cfg_v_fp, cfg_v_sw, cfg_v_bp  in  CW each  vertical timing
- cfg_h_pol, cfg_v_pol  in  1 each  sync polarity
- trig_enable  in  1  enables starttrigger
- cfg_busy  out  1  pending config not yet applied
- cfg_error  out  1  one-cycle pulse: load rejected
- counterX, counterY  out  CW each  raw position
- visible_counterX, visible_counterY  out  CW each  position inside active area
- de, hsync, vsync  out  1 each
- frame_start  out  1  pulse on pixel (0,0) of every frame
- starttrigger  out  1  gated frame-start pulse

## Operation
- Totals: h_total = vis+fp+sw+bp computed in CW+2 bits; same for v.
- counterX 0..h_total-1, wraps to 0 and increments counterY; counterY 0..v_total-1, wraps to 0.
- Active: x < h_vis and y < v_vis -> de=1; visible_counterX/Y = counterX/Y, else both 0.
- hsync active when h_vis+h_fp <= x < h_vis+h_fp+h_sw; vsync likewise on y; active level = pol, inactive = ~pol. sw=0 -> sync never active.
- Validation on cfg_load: reject if h_vis=0, v_vis=0, or either total >= 2^CW. Reject -> cfg_error pulse, pending unchanged, cfg_busy unchanged.
- Accepted load -> pending register written, cfg_busy=1. Later loads before apply overwrite pending.
- Apply point: x=h_total-1 and y=v_total-1 (last pixel). If cfg_busy, pending becomes active; counters go to (0,0) either way; cfg_busy cleared. Accepted load in the apply cycle is applied at that same boundary.
- Frame counter (16 bit) counts frames modulo TRIG_DIV; frame_start on (0,0) every frame; starttrigger = frame_start and frame index = 0 and trig_enable (sampled at (0,0)).
- Reset: active config = parameters, counters (0,0), frame index 0, pending cleared.

## Timing
- All raster outputs delayed exactly LATENCY cycles from internal counter state; cfg_busy and cfg_error are 1-cycle registered, not delayed.
- Reset values: counters and visible counters 0, de 0, frame_start 0, starttrigger 0, cfg_busy 0, cfg_error 0, hsync=~H_POL, vsync=~V_POL (all delay stages).
- First cycle after reset release: internal position (0,0); de=1 appears on output after LATENCY cycles; first frame_start/starttrigger at that same cycle.
- New config visible at output LATENCY cycles after apply; no partial line or frame in old/new mix.
- Reset mid-frame or mid-pending: pending discarded, back to parameter mode immediately (async).

## Test plan
- Params H 4/1/2/1, V 3/1/1/1, LATENCY=1, pol 0: h_total 8, v_total 6; de high 4 of 8 pixels on lines 0..2, hsync low at x=5,6, vsync low on line 4, frame period 48 cycles.
- cfg_load H 2/1/1/1 V 2/1/1/1 pol 1 mid-frame: cfg_busy=1 until last pixel of current frame; next frame period 25, hsync high at x=3.
- cfg_load with h_vis=0, and with totals 4096 at CW=12: cfg_error pulse, cfg_busy stays 0, timing unchanged.
- TRIG_DIV=3, trig_enable=1: starttrigger on frames 0,3,6; frame_start every frame; trig_enable=0 -> no starttrigger.
- LATENCY=4: all raster outputs shifted 4 cycles vs LATENCY=1 run, identical sequence.
- Assert reset at counterY=2 with pending config: outputs return to reset values same cycle; after release, parameter timing, cfg_busy=0.
